// File: rtl/if_prefetch_pkg.sv
// if_prefetch shared constants and helpers.
// Build option: IF_BYPASS_EN (response bypass to ID when queue empty).
package if_prefetch_pkg;

  localparam int IF_ADDR_W = 32;
  localparam int IF_DATA_W = 32;
  localparam int IF_DEPTH = 4;
  localparam int IF_PC_STEP = 4;
  localparam logic [31:0] IF_RESET_PC = 32'h0;

  // queue occupancy counter width for a given depth
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// if_prefetch bus: control, ROM request/response and ID handshake.
// master = fetch stage, slave = ROM/ID/control side.
interface if_prefetch_if
  import if_prefetch_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W,
  parameter int OCC_W = occ_w(IF_DEPTH)
) ();

  logic              halt_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;
  logic [OCC_W-1:0]  occupancy_o;

  modport master (
    input  halt_i, redirect_i, redirect_pc_i,
    input  rom_data_i, id_ready_i,
    output rom_ce_o, rom_addr_o,
    output id_valid_o, id_pc_o, id_inst_o,
    output occupancy_o
  );

  modport slave (
    output halt_i, redirect_i, redirect_pc_i,
    output rom_data_i, id_ready_i,
    input  rom_ce_o, rom_addr_o,
    input  id_valid_o, id_pc_o, id_inst_o,
    input  occupancy_o
  );

endinterface

// File: rtl/if_prefetch_q.sv
// if_prefetch_q: synchronous FIFO holding {pc, inst} fetch entries.
// Flush beats push and pop in the same cycle.
module if_prefetch_q
  import if_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = IF_DEPTH,
  parameter int CNT_W = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  // pointers and count; flush empties the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~do_pop)
        count <= count + 1'b1;
      else if (do_pop & ~do_push)
        count <= count - 1'b1;
    end
  end

  // entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: fetch stage owning the PC, issuing ROM reads and queueing results.
// Build option: IF_BYPASS_EN lets a response reach ID directly when the queue is empty.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W,
  parameter int DEPTH = IF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input logic          clk,
  input logic          rst,
  if_prefetch_if.master bus
);

  localparam int OCC_W = occ_w(DEPTH);
  localparam int CR_W = OCC_W + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [EW-1:0]     q_dout;
  logic [EW-1:0]     head;
  logic              q_full;
  logic              q_empty;
  logic [OCC_W-1:0]  q_count;
  logic              q_push;
  logic              q_pop;
  logic              resp;
  logic              xfer;
  logic              valid;
  logic              room;
  logic [CR_W-1:0]   pend;
  logic              ce;
  logic [ADDR_W-1:0] addr;

  assign resp = inflight & ~bus.redirect_i;
  assign xfer = valid & bus.id_ready_i;

`ifdef IF_BYPASS_EN
  logic byp;
  assign byp    = q_empty & resp;
  assign valid  = (~q_empty | byp) & ~bus.redirect_i;
  assign head   = byp ? {inflight_pc, bus.rom_data_i} : q_dout;
  assign q_push = resp & ~q_full & ~(byp & bus.id_ready_i);
  assign q_pop  = xfer & ~byp;
`else
  assign valid  = ~q_empty & ~bus.redirect_i;
  assign head   = q_dout;
  assign q_push = resp & ~q_full;
  assign q_pop  = xfer;
`endif

  // credit: entries held plus in flight, minus what leaves now
  assign pend = CR_W'(q_count) + CR_W'(inflight) - CR_W'(xfer);
  assign room = pend < CR_W'(DEPTH);

  assign ce   = rst & ~bus.halt_i & (bus.redirect_i | room);
  assign addr = bus.redirect_i ? bus.redirect_pc_i : pc;

  assign bus.rom_ce_o    = ce;
  assign bus.rom_addr_o  = addr;
  assign bus.id_valid_o  = valid;
  assign bus.id_pc_o     = valid ? head[EW-1:DATA_W] : '0;
  assign bus.id_inst_o   = valid ? head[DATA_W-1:0] : '0;
  assign bus.occupancy_o = q_count;

  // PC and in-flight tracking; redirect wins over halt for the PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= ce;
      inflight_pc <= addr;
      if (ce)
        pc <= addr + ADDR_W'(IF_PC_STEP);
      else if (bus.redirect_i)
        pc <= bus.redirect_pc_i;
    end
  end

  if_prefetch_q #(
    .WIDTH(EW),
    .DEPTH(DEPTH),
    .CNT_W(OCC_W)
  ) u_q (
    .clk  (clk),
    .rst  (rst),
    .push (q_push),
    .pop  (q_pop),
    .flush(bus.redirect_i),
    .din  ({inflight_pc, bus.rom_data_i}),
    .dout (q_dout),
    .full (q_full),
    .empty(q_empty),
    .count(q_count)
  );

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed vectors for the fetch stage, ROM[i] = i.
// Cycle 0 is the cycle in which reset is released.
module tb_if_prefetch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  if_prefetch_if #(.ADDR_W(32), .DATA_W(32), .OCC_W(3)) bus ();

  if_prefetch #(
    .ADDR_W(32),
    .DATA_W(32),
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // one-cycle ROM returning word index
  always @(posedge clk)
    if (bus.rom_ce_o)
      bus.rom_data_i <= bus.rom_addr_o >> 2;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ce"}, bus.rom_ce_o, 0);
    chk({tag, "_vld"}, bus.id_valid_o, 0);
    chk({tag, "_pc"}, bus.id_pc_o, 0);
    chk({tag, "_inst"}, bus.id_inst_o, 0);
    chk({tag, "_occ"}, bus.occupancy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    bus.halt_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.id_ready_i = 1'b1;
    bus.rom_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
`ifdef IF_BYPASS_EN
    do_reset();
    #1;
    chk("b0_vld", bus.id_valid_o, 0);
    chk("b0_ce", bus.rom_ce_o, 1);
    nxt(); #1;
    chk("b1_vld", bus.id_valid_o, 1);
    chk("b1_pc", bus.id_pc_o, 0);
    chk("b1_occ", bus.occupancy_o, 0);
    nxt(); #1;
    chk("b2_pc", bus.id_pc_o, 4);
    chk("b2_inst", bus.id_inst_o, 1);
    bus.id_ready_i = 1'b0;
    #1;
    chk("b2_vld", bus.id_valid_o, 1);
    nxt(); #1;
    chk("b3_occ", bus.occupancy_o, 1);
    chk("b3_pc", bus.id_pc_o, 4);
    rst = 1'b0;
    #1;
    chk_zero("b_arst");
`else
    // back-to-back from reset
    do_reset();
    #1;
    chk("c0_ce", bus.rom_ce_o, 1);
    chk("c0_addr", bus.rom_addr_o, 0);
    chk("c0_vld", bus.id_valid_o, 0);
    nxt(); #1;
    chk("c1_addr", bus.rom_addr_o, 4);
    chk("c1_vld", bus.id_valid_o, 0);
    nxt(); #1;
    chk("c2_vld", bus.id_valid_o, 1);
    chk("c2_pc", bus.id_pc_o, 0);
    chk("c2_inst", bus.id_inst_o, 0);
    chk("c2_addr", bus.rom_addr_o, 8);
    nxt(); #1;
    chk("c3_pc", bus.id_pc_o, 4);
    chk("c3_inst", bus.id_inst_o, 1);
    nxt(); #1;
    chk("c4_pc", bus.id_pc_o, 8);
    chk("c4_inst", bus.id_inst_o, 2);
    chk("c4_occ", bus.occupancy_o, 1);

    // ID stalled: queue fills to DEPTH
    bus.id_ready_i = 1'b0;
    do_reset();
    repeat (10) nxt();
    #1;
    chk("st_occ", bus.occupancy_o, 4);
    chk("st_ce", bus.rom_ce_o, 0);
    chk("st_vld", bus.id_valid_o, 1);
    chk("st_pc", bus.id_pc_o, 0);
    chk("st_inst", bus.id_inst_o, 0);
    bus.id_ready_i = 1'b1;
    #1;
    chk("st_ce1", bus.rom_ce_o, 1);
    chk("st_addr", bus.rom_addr_o, 16);
    nxt(); #1;
    chk("c11_pc", bus.id_pc_o, 4);
    chk("c11_occ", bus.occupancy_o, 3);
    nxt(); #1;
    chk("c12_pc", bus.id_pc_o, 8);
    chk("c12_occ", bus.occupancy_o, 3);

    // redirect with 3 queued and 1 in flight
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h100;
    #1;
    chk("rd_vld", bus.id_valid_o, 0);
    chk("rd_ce", bus.rom_ce_o, 1);
    chk("rd_addr", bus.rom_addr_o, 32'h100);
    nxt();
    bus.redirect_i = 1'b0;
    #1;
    chk("rd1_occ", bus.occupancy_o, 0);
    chk("rd1_vld", bus.id_valid_o, 0);
    chk("rd1_addr", bus.rom_addr_o, 32'h104);
    nxt(); #1;
    chk("rd2_pc", bus.id_pc_o, 32'h100);
    chk("rd2_inst", bus.id_inst_o, 32'h40);
    nxt(); #1;
    chk("rd3_pc", bus.id_pc_o, 32'h104);

    // halt for 5 cycles: drain, then resume
    bus.halt_i = 1'b1;
    #1;
    chk("h0_ce", bus.rom_ce_o, 0);
    nxt(); #1;
    chk("h1_pc", bus.id_pc_o, 32'h108);
    chk("h1_inst", bus.id_inst_o, 32'h42);
    chk("h1_ce", bus.rom_ce_o, 0);
    nxt(); #1;
    chk("h2_vld", bus.id_valid_o, 0);
    chk("h2_occ", bus.occupancy_o, 0);
    nxt();
    nxt(); #1;
    chk("h4_vld", bus.id_valid_o, 0);
    chk("h4_ce", bus.rom_ce_o, 0);
    nxt();
    bus.halt_i = 1'b0;
    #1;
    chk("h5_ce", bus.rom_ce_o, 1);
    chk("h5_addr", bus.rom_addr_o, 32'h10C);
    nxt(); #1;
    chk("h6_addr", bus.rom_addr_o, 32'h110);
    nxt(); #1;
    chk("h7_pc", bus.id_pc_o, 32'h10C);

    // PC wrap past the top of the address space
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    #1;
    chk("w0_addr", bus.rom_addr_o, 32'hFFFF_FFF8);
    nxt();
    bus.redirect_i = 1'b0;
    #1;
    chk("w1_addr", bus.rom_addr_o, 32'hFFFF_FFFC);
    nxt(); #1;
    chk("w2_addr", bus.rom_addr_o, 32'h0);
    chk("w2_pc", bus.id_pc_o, 32'hFFFF_FFF8);
    chk("w2_inst", bus.id_inst_o, 32'h3FFF_FFFE);
    nxt(); #1;
    chk("w3_pc", bus.id_pc_o, 32'hFFFF_FFFC);
    nxt(); #1;
    chk("w4_pc", bus.id_pc_o, 32'h0);
    chk("w4_vld", bus.id_valid_o, 1);

    // async reset mid-stream
    rst = 1'b0;
    #1;
    chk_zero("arst");
`endif
    rst = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
